dsp_fir_unit: RTL and testbench
===============================

Name: dsp_fir_unit

Overview:
Parametrised successor to the single-tap DSP unit in the CPU datapath. It is a TAPS-deep FIR/moving-average engine with programmable coefficients and a time-multiplexed single multiplier-accumulator. A start/busy/valid handshake lets the CPU control stall writeback until the filtered result is ready. It sits beside the ALU and feeds the dsporALU writeback mux.

Parameters:
DATA_W, 32, sample and result width (signed two's complement)
COEF_W, 16, coefficient width (signed)
COEF_FRAC, 8, fractional bits in coefficients (Q format)
TAPS, 4, delay-line depth; power of 2, 2..32
ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width (derived localparam, not overridable)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
dsp_control  in  5  [2:0] mode, [4:3] extra arithmetic right shift 0..3
in_valid  in  1  sample_in valid / start request
sample_in  in  DATA_W  input sample (CPU ReadData1)
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  coefficient index
coef_data  in  COEF_W  coefficient value
busy  out  1  engine not in IDLE
out_valid  out  1  one-cycle result strobe
filtered_out  out  DATA_W  registered result
saturated  out  1  result clipped (sticky until next accepted sample)

Behaviour:
- Reset (reset low, asynchronous): FSM=IDLE; delay line=0; acc=0; idx=0; busy=0, out_valid=0, filtered_out=0, saturated=0; coef[0]=1<<COEF_FRAC, all other coefs=0 (identity filter).
- Modes (dsp_control[2:0]): 000 bypass; 001 FIR; 010 moving average; 011 clear; 100-111 reserved, treated as bypass.
- FSM states: IDLE, MAC, OUT.
- IDLE, in_valid=1, mode FIR/avg: shift sample_in into x[0] (x[k]<=x[k-1], x[TAPS-1] dropped); acc=0, idx=0, saturated=0; go to MAC.
- IDLE, in_valid=1, mode bypass: go to OUT with result=sample_in; delay line is not shifted.
- IDLE, in_valid=1, mode clear: zero the delay line and acc; stay in IDLE; no out_valid.
- MAC: acc += x[idx]*c[idx] (FIR) or acc += x[idx]<<COEF_FRAC (avg), full-precision signed; idx++. When idx==TAPS-1, do the last MAC and go to OUT.
- OUT: FIR result = acc >>> (COEF_FRAC+shift). Avg result = acc >>> (COEF_FRAC+log2(TAPS)+shift). Register the result to filtered_out, pulse out_valid for 1 cycle, return to IDLE.
- Latency: out_valid is high in the cycle after TAPS+1 edges following the accept edge (FIR/avg), or 1 edge following it (bypass).
- busy=1 in MAC and OUT. in_valid while busy is ignored (sample dropped, no state change).
- Mode is sampled only at the accept edge; changes mid-operation have no effect.
- coef_we is honoured only in IDLE and ignored while busy. A simultaneous in_valid and coef_we in IDLE applies both; the new coefficient is used by that run.
- filtered_out holds its value until the next OUT.
- Narrowing ACC_W to DATA_W: see optional feature.
- reset asserted mid-MAC: immediate return to reset state; no out_valid is produced.

Optional Feature:
DSP_SAT_EN: when defined, a result outside the DATA_W signed range is clamped to 2^(DATA_W-1)-1 or -2^(DATA_W-1), and saturated is set to 1. When undefined, the low DATA_W bits are taken (wrap) and saturated is tied to 0.

Test Plan:
1. Release reset, idle 5 cycles -> busy=0, out_valid=0, filtered_out=0, saturated=0; FIR mode, sample 100 -> out_valid 5 edges later, filtered_out=100 (default identity).
2. Mode 010, samples 4,8,12,16 back-to-back (waiting on out_valid each time) -> outputs 1,3,6,10.
3. Write coefs [256,256,0,0], FIR, samples 10 then 20 -> outputs 10 then 30. coef_we pulsed while busy -> no change to the following result.
4. FIR, in_valid re-asserted each cycle while busy -> only the first sample is accepted; exactly one out_valid; next result confirms the delay line shifted once.
5. DSP_SAT_EN defined, coef[0]=0x7FFF, sample 0x7FFFFFFF -> filtered_out=0x7FFFFFFF, saturated=1. Macro undefined -> wrapped value, saturated=0.
6. Assert reset during the 2nd MAC cycle -> busy=0 immediately, no out_valid; next FIR sample 7 -> output 7 (delay line zeroed).

Source files
------------

// File: rtl/dsp_fir_if.sv
// dsp_fir_if: CPU-side handshake and coefficient bus for dsp_fir_unit.
//   master : driven by the CPU control/datapath (mode, samples, coefficient writes)
//   slave  : the FIR engine (busy, result strobe, filtered result, saturation flag)
// Signals:
//   dsp_control  [2:0] mode, [4:3] extra arithmetic right shift
//   in_valid     sample_in valid / start request
//   sample_in    input sample (signed)
//   coef_we      coefficient write strobe, coef_addr / coef_data select and value
//   busy         engine not idle
//   out_valid    one-cycle result strobe
//   filtered_out registered result
//   saturated    result clipped (sticky until next accepted sample)
interface dsp_fir_if #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int TAPS   = 4
);
  localparam int IDX_W = $clog2(TAPS);

  logic [4:0]        dsp_control;
  logic              in_valid;
  logic [DATA_W-1:0] sample_in;
  logic              coef_we;
  logic [IDX_W-1:0]  coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              busy;
  logic              out_valid;
  logic [DATA_W-1:0] filtered_out;
  logic              saturated;

  modport master (
    output dsp_control, in_valid, sample_in, coef_we, coef_addr, coef_data,
    input  busy, out_valid, filtered_out, saturated
  );

  modport slave (
    input  dsp_control, in_valid, sample_in, coef_we, coef_addr, coef_data,
    output busy, out_valid, filtered_out, saturated
  );
endinterface

// File: rtl/dsp_fir_unit.sv
// dsp_fir_unit: TAPS-deep FIR / moving-average engine with one time-multiplexed
// multiplier-accumulator. Sits beside the ALU; the CPU stalls writeback on busy
// and picks up filtered_out when out_valid pulses.
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous, active-low reset
//   bus    dsp_fir_if.slave (mode/sample handshake, coefficient writes, result)
// Modes (dsp_control[2:0]): 000 bypass, 001 FIR, 010 moving average, 011 clear,
// 100-111 behave as bypass. dsp_control[4:3] adds an extra arithmetic right shift.
// Optional build macro DSP_SAT_EN: clamp out-of-range results to the DATA_W signed
// limits and flag saturated; without it the low DATA_W bits are kept (wrap).
module dsp_fir_unit #(
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 8,
  parameter int TAPS      = 4
) (
  input  logic     clock,
  input  logic     reset,
  dsp_fir_if.slave bus
);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int IDX_W = $clog2(TAPS);
  localparam int LOG2T = $clog2(TAPS);
  localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(TAPS - 1);
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << COEF_FRAC;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;
  typedef enum logic [1:0] {OP_BYP, OP_FIR, OP_AVG} op_t;

  state_t                   state;
  op_t                      op_q;
  logic [1:0]               shift_q;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] x    [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic                     out_valid_q;
  logic [DATA_W-1:0]        result_q;
  logic                     sat_q;

  // MAC datapath: one tap per cycle, full precision.
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         term;
  logic signed [ACC_W-1:0]         shifted;
  logic [7:0]                      shamt;
  logic [DATA_W-1:0]               result_n;
  logic                            sat_n;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    prod = x[idx] * coef[idx];
    term = '0;
    if (op_q == OP_AVG) begin
      term = ACC_W'(x[idx]);
      term = term <<< COEF_FRAC;
    end else begin
      term = prod;
    end
  end

  // Output scaling: drop the coefficient fraction, the 1/TAPS for averaging and
  // the extra user shift. Bypass passes the sample unscaled.
  always_comb begin
    shamt = 8'd0;
    unique case (op_q)
      OP_FIR:  shamt = 8'(COEF_FRAC) + 8'(shift_q);
      OP_AVG:  shamt = 8'(COEF_FRAC) + 8'(LOG2T) + 8'(shift_q);
      default: shamt = 8'd0;
    endcase
    shifted = acc >>> shamt;
  end

`ifdef DSP_SAT_EN
  logic [ACC_W-DATA_W:0] hi;
  logic                  fits;
  always_comb begin
    hi   = shifted[ACC_W-1:DATA_W-1];
    // In range when the discarded bits are all copies of the result sign bit.
    fits = (&hi) | ~(|hi);
    if (fits) begin
      result_n = shifted[DATA_W-1:0];
      sat_n    = 1'b0;
    end else begin
      result_n = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
      sat_n    = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^shifted[ACC_W-1:DATA_W];
  always_comb begin
    result_n = shifted[DATA_W-1:0];
    sat_n    = 1'b0;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_q        <= OP_BYP;
      shift_q     <= '0;
      idx         <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      // NOTE: the delay line and coefficient bank are small register arrays, reset
      // explicitly so the unit powers up as a clean identity filter.
      for (int k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        coef[k] <= (k == 0) ? COEF_ONE : '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Written here so a same-cycle start already sees the new coefficient.
          if (bus.coef_we) coef[bus.coef_addr] <= bus.coef_data;
          if (bus.in_valid) begin
            shift_q <= bus.dsp_control[4:3];
            unique case (bus.dsp_control[2:0])
              3'b001, 3'b010: begin
                for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
                x[0]  <= bus.sample_in;
                acc   <= '0;
                idx   <= '0;
                sat_q <= 1'b0;
                op_q  <= (bus.dsp_control[2:0] == 3'b001) ? OP_FIR : OP_AVG;
                state <= S_MAC;
              end
              3'b011: begin
                for (int k = 0; k < TAPS; k++) x[k] <= '0;
                acc <= '0;
              end
              default: begin
                // Bypass reuses the accumulator as the holding register.
                acc   <= {{(ACC_W-DATA_W){bus.sample_in[DATA_W-1]}}, bus.sample_in};
                op_q  <= OP_BYP;
                sat_q <= 1'b0;
                state <= S_OUT;
              end
            endcase
          end
        end
        S_MAC: begin
          acc <= acc + term;
          idx <= idx + IDX_W'(1);
          if (idx == IDX_LAST) state <= S_OUT;
        end
        S_OUT: begin
          result_q    <= result_n;
          sat_q       <= sat_n;
          out_valid_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != S_IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.filtered_out = result_q;
  assign bus.saturated    = sat_q;
endmodule

// File: tb/tb_dsp_fir_unit.sv
// tb_dsp_fir_unit: directed self-checking bench for dsp_fir_unit (TAPS=4,
// COEF_FRAC=8). Expected values are hand-computed from the filter definition.
module tb_dsp_fir_unit;
  localparam logic [4:0] C_BYP  = 5'b00_000;
  localparam logic [4:0] C_FIR  = 5'b00_001;
  localparam logic [4:0] C_AVG  = 5'b00_010;
  localparam logic [4:0] C_CLR  = 5'b00_011;
  localparam logic [4:0] C_RSV  = 5'b00_101;
  localparam logic [4:0] C_FIR2 = 5'b10_001;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  dsp_fir_if #(.DATA_W(32), .COEF_W(16), .TAPS(4)) bus ();

  dsp_fir_unit #(.DATA_W(32), .COEF_W(16), .COEF_FRAC(8), .TAPS(4)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [4:0] ctl, input logic [31:0] s);
    @(negedge clock);
    bus.dsp_control = ctl;
    bus.sample_in   = s;
    bus.in_valid    = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic coef_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clock);
    bus.coef_we   = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = d;
    @(posedge clock);
    #1;
    bus.coef_we = 1'b0;
  endtask

  // Counts edges until out_valid is seen (bounded), then checks latency and value.
  task automatic wait_out(input string tag, input int exp_lat, input logic [31:0] exp_val);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!bus.out_valid && n < 40);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_val"}, 64'(bus.filtered_out), 64'(exp_val));
  endtask

  task automatic do_clear(input string tag);
    int seen;
    seen = 0;
    accept(C_CLR, 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid || bus.busy) seen++;
      @(posedge clock);
      #1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int n_ov;
    logic [31:0] got;
    logic [31:0] exp_wrap;
    logic        exp_sat;
    n_tests = 0;
    n_fail  = 0;
    reset           = 1'b0;
    bus.dsp_control = '0;
    bus.in_valid    = 1'b0;
    bus.sample_in   = '0;
    bus.coef_we     = 1'b0;
    bus.coef_addr   = '0;
    bus.coef_data   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // 1: reset state and default identity filter.
    repeat (5) @(posedge clock);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ov", 64'(bus.out_valid), 64'd0);
    check("rst_out", 64'(bus.filtered_out), 64'd0);
    check("rst_sat", 64'(bus.saturated), 64'd0);
    accept(C_FIR, 32'd100);
    wait_out("t1_fir", 5, 32'd100);

    // 2: moving average over fresh history.
    do_clear("t2_clr");
    accept(C_AVG, 32'd4);  wait_out("t2_a0", 5, 32'd1);
    accept(C_AVG, 32'd8);  wait_out("t2_a1", 5, 32'd3);
    accept(C_AVG, 32'd12); wait_out("t2_a2", 5, 32'd6);
    accept(C_AVG, 32'd16); wait_out("t2_a3", 5, 32'd10);

    // 3: programmed two-tap filter; coefficient write while busy is ignored.
    do_clear("t3_clr");
    coef_wr(2'd0, 16'd256);
    coef_wr(2'd1, 16'd256);
    accept(C_FIR, 32'd10); wait_out("t3_f0", 5, 32'd10);
    accept(C_FIR, 32'd20); wait_out("t3_f1", 5, 32'd30);
    accept(C_FIR, 32'd30);
    coef_wr(2'd1, 16'd0);
    wait_out("t3_busy_we", 4, 32'd50);

    // 4: in_valid held while busy; only the first sample is taken.
    @(negedge clock);
    bus.dsp_control = C_FIR;
    bus.sample_in   = 32'd5;
    bus.in_valid    = 1'b1;
    @(posedge clock);
    #1;
    bus.sample_in = 32'd99;
    n_ov = 0;
    got  = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      if (bus.out_valid) begin
        n_ov++;
        got = bus.filtered_out;
      end
      if (i == 4) bus.in_valid = 1'b0;
    end
    check("t4_ov_count", 64'(n_ov), 64'd1);
    check("t4_val", 64'(got), 64'd35);
    accept(C_FIR, 32'd1);
    wait_out("t4_next", 5, 32'd6);

    // 5: overflow: clamp with DSP_SAT_EN, wrap otherwise.
    coef_wr(2'd0, 16'h7FFF);
    coef_wr(2'd1, 16'd0);
`ifdef DSP_SAT_EN
    exp_wrap = 32'h7FFF_FFFF;
    exp_sat  = 1'b1;
`else
    exp_wrap = 32'hFF7F_FF80;
    exp_sat  = 1'b0;
`endif
    accept(C_FIR, 32'h7FFF_FFFF);
    wait_out("t5_ovf", 5, exp_wrap);
    check("t5_sat", 64'(bus.saturated), 64'(exp_sat));

    // 6: reset during the second MAC cycle.
    accept(C_FIR, 32'd50);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("t6_busy", 64'(bus.busy), 64'd0);
    n_ov = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) n_ov++;
      @(posedge clock);
      #1;
      if (i == 2) reset = 1'b1;
    end
    check("t6_no_ov", 64'(n_ov), 64'd0);
    check("t6_out", 64'(bus.filtered_out), 64'd0);
    check("t6_sat", 64'(bus.saturated), 64'd0);
    accept(C_FIR, 32'd7);
    wait_out("t6_fir", 5, 32'd7);

    // Extra shift on a negative sample, bypass and reserved-mode bypass.
    accept(C_FIR2, 32'hFFFF_FFF8);
    wait_out("shift_neg", 5, 32'hFFFF_FFFE);
    accept(C_BYP, 32'hDEAD_BEEF);
    wait_out("bypass", 1, 32'hDEAD_BEEF);
    accept(C_RSV, 32'h1234_5678);
    wait_out("reserved", 1, 32'h1234_5678);
    repeat (4) @(posedge clock);
    #1;
    check("hold_out", 64'(bus.filtered_out), 64'h1234_5678);
    // Bypass left the delay line alone: x = [-8, 7, 0, 0] with identity coefs.
    accept(C_FIR, 32'd3);
    wait_out("after_byp", 5, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
